// File: rtl/cv32e40p_apu_responder_if.sv
// APU interconnect bundle: core request/response channel plus engine issue/result channel.
interface cv32e40p_apu_responder_if #(
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NUSFLAGS_CPU = 5
);
  logic                              apu_req;
  logic                              apu_gnt;
  logic [APU_NARGS_CPU-1:0][31:0]    apu_operands;
  logic [APU_WOP_CPU-1:0]            apu_op;
  logic                              apu_rvalid;
  logic [31:0]                       apu_result;
  logic [APU_NUSFLAGS_CPU-1:0]       apu_rflags;
  logic                              eng_valid;
  logic                              eng_ready;
  logic [APU_NARGS_CPU-1:0][31:0]    eng_operands;
  logic [APU_WOP_CPU-1:0]            eng_op;
  logic                              eng_done;
  logic [31:0]                       eng_result;
  logic [APU_NUSFLAGS_CPU-1:0]       eng_flags;

  // master: core + engine side; slave: the responder
  modport master (
    output apu_req, apu_operands, apu_op, eng_ready, eng_done, eng_result, eng_flags,
    input  apu_gnt, apu_rvalid, apu_result, apu_rflags, eng_valid, eng_operands, eng_op
  );
  modport slave (
    input  apu_req, apu_operands, apu_op, eng_ready, eng_done, eng_result, eng_flags,
    output apu_gnt, apu_rvalid, apu_result, apu_rflags, eng_valid, eng_operands, eng_op
  );
endinterface

// File: rtl/cv32e40p_apu_responder.sv
// APU responder: queues core requests in a small FIFO, issues them one at a time to an
// execution engine and returns each result in order as a single-cycle rvalid pulse.
module cv32e40p_apu_responder #(
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NUSFLAGS_CPU = 5,
  parameter int unsigned DEPTH            = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cv32e40p_apu_responder_if.slave     bus,
  output logic                        busy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                         state;
  logic [APU_WOP_CPU-1:0]         op_mem  [DEPTH];
  logic [APU_NARGS_CPU-1:0][31:0] opd_mem [DEPTH];
  logic [PW-1:0]                  wr_ptr;
  logic [PW-1:0]                  rd_ptr;
  logic [CW-1:0]                  count;
  logic                           empty;
  logic                           full;
  logic                           push;
  logic                           pop;
  logic                           more;
  logic                           eng_valid;
  logic                           rvalid;
  logic [31:0]                    result;
  logic [APU_NUSFLAGS_CPU-1:0]    rflags;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign push  = bus.apu_req & ~full;
  assign pop   = (state == ISSUE) & bus.eng_ready;
  // Work pending once this cycle's push lands; only used in states that never pop
  assign more  = ~empty | push;

  assign bus.apu_gnt      = push;
  assign bus.eng_valid    = eng_valid;
  assign bus.eng_op       = op_mem[rd_ptr];
  assign bus.eng_operands = opd_mem[rd_ptr];
  assign bus.apu_rvalid   = rvalid;
  assign bus.apu_result   = result;
  assign bus.apu_rflags   = rflags;
  assign busy             = ~empty | (state != IDLE);

  // Request FIFO; storage is cleared so a reset discards queued contents entirely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        op_mem[i]  <= '0;
        opd_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        op_mem[wr_ptr]  <= bus.apu_op;
        opd_mem[wr_ptr] <= bus.apu_operands;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Issue/wait sequencer with registered engine valid and core response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      eng_valid <= 1'b0;
      rvalid    <= 1'b0;
      result    <= '0;
      rflags    <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (more) begin
            state     <= ISSUE;
            eng_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.eng_ready) begin
            state     <= WAIT;
            eng_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.eng_done) begin
            rvalid <= 1'b1;
            result <= bus.eng_result;
            rflags <= bus.eng_flags;
            if (more) begin
              state     <= ISSUE;
              eng_valid <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          eng_valid <= 1'b0;
        end
      endcase
    end
  end

  // A done pulse with no operation in the engine is an engine protocol error
  a_done_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    bus.eng_done |-> (state == WAIT));

endmodule
